// File: rtl/pipe_reg_chain_pkg.sv
// Shared constants and helpers for the pipe_reg_chain register pipeline.
// Build option: PIPE_REG_CHAIN_SKID_EN adds a skid register per stage (CAP = 2*DEPTH).
package pipe_reg_pkg;

    localparam int unsigned            DEF_WIDTH     = 16;
    localparam int unsigned            DEF_DEPTH     = 2;
    localparam logic [DEF_WIDTH-1:0]   DEF_RESET_VAL = '0;

    // Fill level of one stage; ST_FULL only exists with a skid register.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_MAIN  = 2'd1,
        ST_FULL  = 2'd2
    } stage_st_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int unsigned chain_cap(input int unsigned depth);
`ifdef PIPE_REG_CHAIN_SKID_EN
        return 2 * depth;
`else
        return depth;
`endif
    endfunction

    function automatic int unsigned occ_width(input int unsigned cap);
        return clog2(cap + 1);
    endfunction

endpackage

// File: rtl/pipe_reg_chain_stage.sv
// One valid/ready register stage: main register plus, when PIPE_REG_CHAIN_SKID_EN
// is defined, a skid register that keeps upstream ready registered.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_EMPTY | no word held, upstream ready
//   ST_MAIN  | main register holds the oldest word
//   ST_FULL  | main and skid both hold words, upstream stalled
module pipe_reg_stage
    import pipe_reg_pkg::*;
#(
    parameter int unsigned      WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    stage_st_e        state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic             in_fire, out_fire;

`ifdef PIPE_REG_CHAIN_SKID_EN
    logic [WIDTH-1:0] skid_q, skid_d;

    // Depends on state only, so no combinational path from downstream ready.
    assign in_ready_o = (state_q != ST_FULL);
`else
    assign in_ready_o = (state_q == ST_EMPTY) || out_ready_i;
`endif

    assign out_valid_o = (state_q != ST_EMPTY);
    assign out_data_o  = main_q;
    assign in_fire     = in_valid_i && in_ready_o;
    assign out_fire    = out_valid_o && out_ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
`ifdef PIPE_REG_CHAIN_SKID_EN
        skid_d  = skid_q;
`endif
        if (flush_i) begin
            state_d = ST_EMPTY;
            main_d  = RESET_VAL;
`ifdef PIPE_REG_CHAIN_SKID_EN
            skid_d  = RESET_VAL;
`endif
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_data_i;
                        state_d = ST_MAIN;
                    end
                end
                ST_MAIN: begin
                    if (out_fire) begin
                        if (in_fire) begin
                            main_d = in_data_i;
                        end else begin
                            state_d = ST_EMPTY;
                        end
                    end
`ifdef PIPE_REG_CHAIN_SKID_EN
                    else if (in_fire) begin
                        skid_d  = in_data_i;
                        state_d = ST_FULL;
                    end
`endif
                end
`ifdef PIPE_REG_CHAIN_SKID_EN
                ST_FULL: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = ST_MAIN;
                    end
                end
`endif
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            state_q <= ST_EMPTY;
            main_q  <= RESET_VAL;
`ifdef PIPE_REG_CHAIN_SKID_EN
            skid_q  <= RESET_VAL;
`endif
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
`ifdef PIPE_REG_CHAIN_SKID_EN
            skid_q  <= skid_d;
`endif
        end
    end

endmodule

// File: rtl/pipe_reg_chain.sv
// DEPTH-stage valid/ready register pipeline with flush and occupancy count.
// Build option: PIPE_REG_CHAIN_SKID_EN selects skid stages and a registered in_ready_o.
module pipe_reg_chain
    import pipe_reg_pkg::*;
#(
    parameter int unsigned      WIDTH     = DEF_WIDTH,
    parameter int unsigned      DEPTH     = DEF_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEF_RESET_VAL),
    localparam int unsigned     CAP       = chain_cap(DEPTH),
    localparam int unsigned     OCC_W     = occ_width(CAP)
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [OCC_W-1:0] occupancy_o
);

    logic             head_rdy;
    logic             in_fire, out_fire;
    logic [OCC_W-1:0] occ_q, occ_d;

    // Per-stage signals live in their own generate scope so the ready chain
    // does not form a self-referencing vector.
    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic             v_in, v_out, rdy_up, rdy_dn;
        logic [WIDTH-1:0] d_in, d_out;

        if (g == 0) begin : g_head
            assign v_in = in_valid_i;
            assign d_in = in_data_i;
        end else begin : g_link
            assign v_in = g_stage[g-1].v_out;
            assign d_in = g_stage[g-1].d_out;
        end

        if (g == DEPTH - 1) begin : g_tail
            assign rdy_dn = out_ready_i;
        end else begin : g_back
            assign rdy_dn = g_stage[g+1].rdy_up;
        end

        pipe_reg_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk_i       (clk_i),
            .clr_i       (clr_i),
            .flush_i     (flush_i),
            .in_valid_i  (v_in),
            .in_ready_o  (rdy_up),
            .in_data_i   (d_in),
            .out_valid_o (v_out),
            .out_ready_i (rdy_dn),
            .out_data_o  (d_out)
        );
    end

    assign head_rdy    = g_stage[0].rdy_up;
    assign in_ready_o  = head_rdy && !clr_i;
    assign out_valid_o = g_stage[DEPTH-1].v_out;
    assign out_data_o  = g_stage[DEPTH-1].d_out;

    assign in_fire  = in_valid_i && in_ready_o;
    assign out_fire = out_valid_o && out_ready_i;

    always_comb begin
        occ_d = occ_q;
        if (flush_i) begin
            occ_d = '0;
        end else if (in_fire && !out_fire) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!in_fire && out_fire) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy_o = occ_q;

endmodule
